// File: rtl/sap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sap_ctrl_pkg
// Shared definitions for the SAP-1 controller-sequencer slice: default
// widths, the opcode map, the control-word bit positions, the packed
// control-word struct and a helper that sorts an opcode into the class
// the decoder acts on.
// ---------------------------------------------------------------------------
package sap_ctrl_pkg;

    // Default widths; the ring length is fixed at six states.
    localparam int SAP_OPCODE_W = 4;
    localparam int SAP_CW_W     = 12;
    localparam int SAP_NUM_T    = 6;

    // Opcode map (IR[7:4]).  Anything not listed behaves as a NOP.
    localparam logic [SAP_OPCODE_W-1:0] OP_LDA = 4'b0000;
    localparam logic [SAP_OPCODE_W-1:0] OP_ADD = 4'b0001;
    localparam logic [SAP_OPCODE_W-1:0] OP_SUB = 4'b0010;
    localparam logic [SAP_OPCODE_W-1:0] OP_OUT = 4'b1110;
    localparam logic [SAP_OPCODE_W-1:0] OP_HLT = 4'b1111;

    // Bit positions of each strobe inside the control word.
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    // Control word, MSB first, matching the CW_* positions above.
    typedef struct packed {
        logic cp;   // increment program counter
        logic ep;   // program counter onto W-bus
        logic lm;   // load memory address register
        logic ce;   // RAM onto W-bus
        logic li;   // load instruction register
        logic ei;   // IR operand field onto W-bus
        logic la;   // load accumulator
        logic ea;   // accumulator onto W-bus
        logic su;   // ALU subtract select
        logic eu;   // ALU result onto W-bus
        logic lb;   // load B register
        logic lo;   // load output register
    } ctrl_word_t;

    // Decoder view of an opcode.
    typedef enum logic [2:0] {
        OPC_LDA,
        OPC_ADD,
        OPC_SUB,
        OPC_OUT,
        OPC_HLT,
        OPC_NOP
    } op_class_t;

    // Sorts a raw opcode into its class; unknown codes fall to NOP.
    function automatic op_class_t classify_op(input logic [SAP_OPCODE_W-1:0] op);
        op_class_t cls;
        case (op)
            OP_LDA:  cls = OPC_LDA;
            OP_ADD:  cls = OPC_ADD;
            OP_SUB:  cls = OPC_SUB;
            OP_OUT:  cls = OPC_OUT;
            OP_HLT:  cls = OPC_HLT;
            default: cls = OPC_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/sap_ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// sap_ctrl_seq_if
// Bundle between the controller-sequencer and the rest of the SAP-1 datapath.
//   OPCODE : IR upper nibble into the controller
//   T      : one-hot T-state out of the controller (T[0] = T1)
//   CON    : control word out of the controller, all strobes active-high
//   HLT    : halted flag out of the controller
// master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface sap_ctrl_seq_if
    import sap_ctrl_pkg::*;
#(
    parameter int OPCODE_W = SAP_OPCODE_W,
    parameter int CW_W     = SAP_CW_W,
    parameter int NUM_T    = SAP_NUM_T
);

    logic [OPCODE_W-1:0] OPCODE;
    logic [NUM_T-1:0]    T;
    logic [CW_W-1:0]     CON;
    logic                HLT;

    modport master (
        input  OPCODE,
        output T,
        output CON,
        output HLT
    );

    modport slave (
        output OPCODE,
        input  T,
        input  CON,
        input  HLT
    );

endinterface

// File: rtl/sap_ring_counter.sv
// ---------------------------------------------------------------------------
// sap_ring_counter
// One-hot T-state ring for the SAP-1 sequencer.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset, seeds T1
//   hold    : freeze the ring in its current state (halt)
//   load_t1 : jump straight back to T1 on the next edge (early return)
//   t       : one-hot state, t[0] = T1
// ---------------------------------------------------------------------------
module sap_ring_counter #(
    parameter int NUM_T = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             load_t1,
    output logic [NUM_T-1:0] t
);

    localparam logic [NUM_T-1:0] T1_OH = NUM_T'(1);

    logic [NUM_T-1:0] t_q;
    logic [NUM_T-1:0] t_d;
    logic             is_onehot;

    // A value is one-hot when it is non-zero and clearing its lowest set
    // bit leaves nothing behind.
    always_comb begin
        is_onehot = (t_q != '0) && ((t_q & (t_q - T1_OH)) == '0);
    end

    // Next-state selection.  A corrupted ring re-seeds to T1 before any
    // other request is honoured, so even a halted ring recovers.
    always_comb begin
        t_d = t_q;
        if (!is_onehot) begin
            t_d = T1_OH;
        end else if (hold) begin
            t_d = t_q;
        end else if (load_t1) begin
            t_d = T1_OH;
        end else begin
            t_d = {t_q[NUM_T-2:0], t_q[NUM_T-1]};
        end
    end

    // State register, T1 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q <= T1_OH;
        end else begin
            t_q <= t_d;
        end
    end

    assign t = t_q;

endmodule

// File: rtl/sap_ctrl_seq.sv
// ---------------------------------------------------------------------------
// sap_ctrl_seq
// SAP-1 controller-sequencer.  A six-state one-hot ring steps through
// fetch (T1-T3) and execute (T4-T6); the control word is decoded
// combinationally from the ring state, the IR opcode and the halt flag.
//   CLK : rising-edge clock
//   CLR : asynchronous active-high clear; forces T1, clears HLT and
//         gates CON to zero while high
//   bus : sap_ctrl_seq_if master side (OPCODE in; T, CON, HLT out)
// Optional build macro: CTRL_VARIABLE_CYCLE_EN
//   defined   -> ring returns to T1 right after the last useful state
//                (LDA after T5, OUT/NOP after T4, ADD/SUB use all six)
//   undefined -> every instruction takes the full six states
// ---------------------------------------------------------------------------
module sap_ctrl_seq
    import sap_ctrl_pkg::*;
#(
    parameter int OPCODE_W = SAP_OPCODE_W,
    parameter int CW_W     = SAP_CW_W,
    parameter int NUM_T    = SAP_NUM_T
) (
    input  logic           CLK,
    input  logic           CLR,
    sap_ctrl_seq_if.master bus
);

    // The decode below is written for exactly this geometry.
    if (NUM_T != 6) begin : g_bad_num_t
        $error("sap_ctrl_seq: NUM_T must be 6, got %0d", NUM_T);
    end
    if (OPCODE_W != SAP_OPCODE_W) begin : g_bad_opcode_w
        $error("sap_ctrl_seq: OPCODE_W must be %0d, got %0d", SAP_OPCODE_W, OPCODE_W);
    end
    if (CW_W != $bits(ctrl_word_t)) begin : g_bad_cw_w
        $error("sap_ctrl_seq: CW_W must be %0d, got %0d", $bits(ctrl_word_t), CW_W);
    end

    localparam logic [NUM_T-1:0] T1_OH = NUM_T'(1);
    localparam logic [NUM_T-1:0] T2_OH = NUM_T'(2);
    localparam logic [NUM_T-1:0] T3_OH = NUM_T'(4);
    localparam logic [NUM_T-1:0] T4_OH = NUM_T'(8);
    localparam logic [NUM_T-1:0] T5_OH = NUM_T'(16);
    localparam logic [NUM_T-1:0] T6_OH = NUM_T'(32);

    logic [OPCODE_W-1:0] opcode;
    logic [NUM_T-1:0]    t;
    op_class_t           op_class;
    logic                hlt_q;
    logic                hlt_d;
    logic                load_t1;
    ctrl_word_t          cw;

    assign opcode   = bus.OPCODE;
    assign op_class = classify_op(opcode);

    sap_ring_counter #(
        .NUM_T (NUM_T)
    ) u_ring (
        .clk     (CLK),
        .rst     (CLR),
        .hold    (hlt_q),
        .load_t1 (load_t1),
        .t       (t)
    );

    // Early-return request.  In the fixed build the ring always runs the
    // full six states.
    always_comb begin
        load_t1 = 1'b0;
`ifdef CTRL_VARIABLE_CYCLE_EN
        if (!hlt_q) begin
            if ((t == T4_OH) && ((op_class == OPC_OUT) || (op_class == OPC_NOP))) begin
                load_t1 = 1'b1;
            end
            if ((t == T5_OH) && (op_class == OPC_LDA)) begin
                load_t1 = 1'b1;
            end
        end
`endif
    end

    // Halt latches on the edge that closes T4 of an HLT instruction.  The
    // ring is not yet held on that edge, so it lands in T5 and stays there.
    always_comb begin
        hlt_d = hlt_q;
        if ((t == T4_OH) && (op_class == OPC_HLT)) begin
            hlt_d = 1'b1;
        end
    end

    // Halt flag; only CLR clears it.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            hlt_q <= 1'b0;
        end else begin
            hlt_q <= hlt_d;
        end
    end

    // Control-word decode.  Fetch states ignore the opcode; execute states
    // follow it combinationally.  CLR and halt force every strobe low, and
    // a non-one-hot ring matches no state, so it also yields an idle word.
    always_comb begin
        cw = '0;
        if (!CLR && !hlt_q) begin
            if (t == T1_OH) begin
                cw.ep = 1'b1;
                cw.lm = 1'b1;
            end else if (t == T2_OH) begin
                cw.cp = 1'b1;
            end else if (t == T3_OH) begin
                cw.ce = 1'b1;
                cw.li = 1'b1;
            end else if (t == T4_OH) begin
                case (op_class)
                    OPC_LDA, OPC_ADD, OPC_SUB: begin
                        cw.ei = 1'b1;
                        cw.lm = 1'b1;
                    end
                    OPC_OUT: begin
                        cw.ea = 1'b1;
                        cw.lo = 1'b1;
                    end
                    default: begin
                        cw = '0;
                    end
                endcase
            end else if (t == T5_OH) begin
                case (op_class)
                    OPC_LDA: begin
                        cw.ce = 1'b1;
                        cw.la = 1'b1;
                    end
                    OPC_ADD, OPC_SUB: begin
                        cw.ce = 1'b1;
                        cw.lb = 1'b1;
                    end
                    default: begin
                        cw = '0;
                    end
                endcase
            end else if (t == T6_OH) begin
                // SU only ever appears alongside EU.
                case (op_class)
                    OPC_ADD: begin
                        cw.la = 1'b1;
                        cw.eu = 1'b1;
                    end
                    OPC_SUB: begin
                        cw.la = 1'b1;
                        cw.su = 1'b1;
                        cw.eu = 1'b1;
                    end
                    default: begin
                        cw = '0;
                    end
                endcase
            end
        end
    end

    assign bus.T   = t;
    assign bus.CON = cw;
    assign bus.HLT = hlt_q;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_sap_ctrl_seq
// Directed bench for the SAP-1 controller-sequencer.  Inputs change on the
// falling clock edge and outputs are sampled 1 time unit later; a monitor
// checks the ring and strobe invariants shortly after every rising edge.
// ---------------------------------------------------------------------------
module tb_sap_ctrl_seq;
    import sap_ctrl_pkg::*;

    logic clk;
    logic clr;
    int   compared;
    int   mismatched;

    sap_ctrl_seq_if bus ();

    sap_ctrl_seq u_dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    // 10-unit clock; rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: sim time %0t exceeded, required finish before 50000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Per-cycle invariants: one-hot ring, SU only with EU, idle word under
    // halt or clear.
    always @(posedge clk) begin
        #2;
        compared++;
        if (!$onehot(bus.T)) begin
            mismatched++;
            $display("[TB] FAIL mon_onehot: T=%b, required one-hot", bus.T);
        end
        compared++;
        if (bus.CON[CW_SU] && !bus.CON[CW_EU]) begin
            mismatched++;
            $display("[TB] FAIL mon_su_eu: CON=%h, required SU only with EU", bus.CON);
        end
        compared++;
        if ((bus.HLT || clr) && (bus.CON !== 12'h000)) begin
            mismatched++;
            $display("[TB] FAIL mon_idle: HLT=%b CLR=%b CON=%h, required CON=000", bus.HLT, clr, bus.CON);
        end
    end

    // Reset state, fetch decode, and a CLR pulse in the middle of T3.
    task automatic test_reset();
        @(negedge clk); #1;
        compared++;
        if (bus.T !== 6'b000001 || bus.CON !== 12'h000 || bus.HLT !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_hold: T=%b CON=%h HLT=%b, required 000001/000/0", bus.T, bus.CON, bus.HLT);
        end
        @(negedge clk); clr = 1'b0; #1;
        compared++;
        if (bus.T !== 6'b000001 || bus.CON !== 12'h600) begin
            mismatched++;
            $display("[TB] FAIL reset_t1: T=%b CON=%h, required 000001/600", bus.T, bus.CON);
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
        compared++;
        if (bus.T !== 6'b000100 || bus.CON !== 12'h180) begin
            mismatched++;
            $display("[TB] FAIL reset_pre_t3: T=%b CON=%h, required 000100/180", bus.T, bus.CON);
        end
        clr = 1'b1; #1;
        compared++;
        if (bus.T !== 6'b000001 || bus.CON !== 12'h000 || bus.HLT !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL clr_mid_t3: T=%b CON=%h HLT=%b, required 000001/000/0", bus.T, bus.CON, bus.HLT);
        end
        @(negedge clk); clr = 1'b0; bus.OPCODE = OP_LDA; #1;
        compared++;
        if (bus.T !== 6'b000001 || bus.CON !== 12'h600) begin
            mismatched++;
            $display("[TB] FAIL fetch_t1: T=%b CON=%h, required 000001/600", bus.T, bus.CON);
        end
        @(negedge clk); #1;
        compared++;
        if (bus.T !== 6'b000010 || bus.CON !== 12'h800) begin
            mismatched++;
            $display("[TB] FAIL fetch_t2: T=%b CON=%h, required 000010/800", bus.T, bus.CON);
        end
        @(negedge clk); #1;
        compared++;
        if (bus.T !== 6'b000100 || bus.CON !== 12'h180) begin
            mismatched++;
            $display("[TB] FAIL fetch_t3: T=%b CON=%h, required 000100/180", bus.T, bus.CON);
        end
    endtask

    // LDA execute, continuing from the T3 left by test_reset.
    task automatic test_lda();
        @(negedge clk); #1;
        compared++;
        if (bus.T !== 6'b001000 || bus.CON !== 12'h240) begin
            mismatched++;
            $display("[TB] FAIL lda_t4: T=%b CON=%h, required 001000/240", bus.T, bus.CON);
        end
        @(negedge clk); #1;
        compared++;
        if (bus.T !== 6'b010000 || bus.CON !== 12'h120) begin
            mismatched++;
            $display("[TB] FAIL lda_t5: T=%b CON=%h, required 010000/120", bus.T, bus.CON);
        end
`ifndef CTRL_VARIABLE_CYCLE_EN
        @(negedge clk); #1;
        compared++;
        if (bus.T !== 6'b100000 || bus.CON !== 12'h000) begin
            mismatched++;
            $display("[TB] FAIL lda_t6: T=%b CON=%h, required 100000/000", bus.T, bus.CON);
        end
`endif
        @(negedge clk); #1;
        compared++;
        if (bus.T !== 6'b000001 || bus.CON !== 12'h600) begin
            mismatched++;
            $display("[TB] FAIL lda_next_t1: T=%b CON=%h, required 000001/600", bus.T, bus.CON);
        end
    endtask

    // ADD then SUB back to back, each starting from T1.
    task automatic test_add_sub();
        logic [3:0]  ops   [2];
        logic [11:0] t6_cw [2];
        ops[0] = OP_ADD; t6_cw[0] = 12'h024;
        ops[1] = OP_SUB; t6_cw[1] = 12'h02C;
        for (int i = 0; i < 2; i++) begin
            bus.OPCODE = ops[i];
            @(negedge clk); #1;
            @(negedge clk); #1;
            @(negedge clk); #1;
            compared++;
            if (bus.T !== 6'b001000 || bus.CON !== 12'h240) begin
                mismatched++;
                $display("[TB] FAIL alu%0d_t4: T=%b CON=%h, required 001000/240", i, bus.T, bus.CON);
            end
            @(negedge clk); #1;
            compared++;
            if (bus.T !== 6'b010000 || bus.CON !== 12'h102) begin
                mismatched++;
                $display("[TB] FAIL alu%0d_t5: T=%b CON=%h, required 010000/102", i, bus.T, bus.CON);
            end
            @(negedge clk); #1;
            compared++;
            if (bus.T !== 6'b100000 || bus.CON !== t6_cw[i]) begin
                mismatched++;
                $display("[TB] FAIL alu%0d_t6: T=%b CON=%h, required 100000/%h", i, bus.T, bus.CON, t6_cw[i]);
            end
            @(negedge clk); #1;
            compared++;
            if (bus.T !== 6'b000001 || bus.CON !== 12'h600) begin
                mismatched++;
                $display("[TB] FAIL alu%0d_next_t1: T=%b CON=%h, required 000001/600", i, bus.T, bus.CON);
            end
        end
    endtask

    // OUT, then HLT, a frozen ring under changing opcodes, then CLR.
    task automatic test_out_hlt();
        logic [3:0] op_v;
        bus.OPCODE = OP_OUT;
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        compared++;
        if (bus.T !== 6'b001000 || bus.CON !== 12'h011) begin
            mismatched++;
            $display("[TB] FAIL out_t4: T=%b CON=%h, required 001000/011", bus.T, bus.CON);
        end
`ifndef CTRL_VARIABLE_CYCLE_EN
        @(negedge clk); #1;
        compared++;
        if (bus.T !== 6'b010000 || bus.CON !== 12'h000) begin
            mismatched++;
            $display("[TB] FAIL out_t5: T=%b CON=%h, required 010000/000", bus.T, bus.CON);
        end
        @(negedge clk); #1;
        compared++;
        if (bus.T !== 6'b100000 || bus.CON !== 12'h000) begin
            mismatched++;
            $display("[TB] FAIL out_t6: T=%b CON=%h, required 100000/000", bus.T, bus.CON);
        end
`endif
        @(negedge clk); #1;
        compared++;
        if (bus.T !== 6'b000001) begin
            mismatched++;
            $display("[TB] FAIL out_next_t1: T=%b, required 000001", bus.T);
        end
        bus.OPCODE = OP_HLT;
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        compared++;
        if (bus.T !== 6'b001000 || bus.CON !== 12'h000 || bus.HLT !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL hlt_t4: T=%b CON=%h HLT=%b, required 001000/000/0", bus.T, bus.CON, bus.HLT);
        end
        @(negedge clk); #1;
        compared++;
        if (bus.T !== 6'b010000 || bus.CON !== 12'h000 || bus.HLT !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL hlt_set: T=%b CON=%h HLT=%b, required 010000/000/1", bus.T, bus.CON, bus.HLT);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            op_v = 4'(i * 5);
            bus.OPCODE = op_v;
            #1;
            compared++;
            if (bus.T !== 6'b010000 || bus.CON !== 12'h000 || bus.HLT !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL halted_%0d: T=%b CON=%h HLT=%b, required 010000/000/1", i, bus.T, bus.CON, bus.HLT);
            end
        end
        clr = 1'b1; #1;
        compared++;
        if (bus.T !== 6'b000001 || bus.CON !== 12'h000 || bus.HLT !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL hlt_clr: T=%b CON=%h HLT=%b, required 000001/000/0", bus.T, bus.CON, bus.HLT);
        end
        @(negedge clk); clr = 1'b0; bus.OPCODE = OP_LDA; #1;
        compared++;
        if (bus.T !== 6'b000001 || bus.CON !== 12'h600 || bus.HLT !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL hlt_exit_t1: T=%b CON=%h HLT=%b, required 000001/600/0", bus.T, bus.CON, bus.HLT);
        end
    endtask

    // Instruction lengths for LDA, OUT, NOP, ADD streamed from T1.
    task automatic test_cycle_counts();
        logic [3:0] ops      [4];
        int         exp_len  [4];
        logic [5:0] exp_last [4];
        int         cnt;
        logic [5:0] last_t;
        bit         done;
        ops[0] = OP_LDA; ops[1] = OP_OUT; ops[2] = 4'b0101; ops[3] = OP_ADD;
`ifdef CTRL_VARIABLE_CYCLE_EN
        exp_len[0] = 5; exp_last[0] = 6'b010000;
        exp_len[1] = 4; exp_last[1] = 6'b001000;
        exp_len[2] = 4; exp_last[2] = 6'b001000;
        exp_len[3] = 6; exp_last[3] = 6'b100000;
`else
        for (int i = 0; i < 4; i++) begin
            exp_len[i]  = 6;
            exp_last[i] = 6'b100000;
        end
`endif
        for (int i = 0; i < 4; i++) begin
            bus.OPCODE = ops[i];
            cnt    = 1;
            last_t = 6'b000000;
            done   = 1'b0;
            for (int k = 0; k < 16 && !done; k++) begin
                last_t = bus.T;
                @(negedge clk); #1;
                if (bus.T === 6'b000001) begin
                    done = 1'b1;
                end else begin
                    cnt++;
                    if (i == 2 && bus.T === 6'b001000) begin
                        compared++;
                        if (bus.CON !== 12'h000) begin
                            mismatched++;
                            $display("[TB] FAIL nop_t4: CON=%h, required 000", bus.CON);
                        end
                    end
                end
            end
            compared++;
            if (!done || cnt != exp_len[i] || last_t !== exp_last[i]) begin
                mismatched++;
                $display("[TB] FAIL len_op%0d: returned=%0d cycles=%0d last=%b, required 1/%0d/%b",
                         i, done, cnt, last_t, exp_len[i], exp_last[i]);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        clr        = 1'b1;
        bus.OPCODE = OP_LDA;
        $display("[TB] start");
        test_reset();
        test_lda();
        test_add_sub();
        test_out_hlt();
        test_cycle_counts();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
